// File: rtl/cmd_responder.sv
// rtl/cmd_responder.sv - command bus target executing register commands with a response FIFO
//
// Optional feature macro: CMD_RESP_PARITY_EN (check cmd_parity on every accepted command)
//
// Ports:
//   clk         in   clock, all logic on rising edge
//   rst         in   synchronous active-high reset
//   cmd_valid   in   command present
//   cmd_ready   out  responder can accept a command (registered)
//   cmd_op      in   opcode (NOP/WR/RD/CLR/INC, others illegal)
//   cmd_addr    in   register address
//   cmd_wdata   in   write data
//   cmd_parity  in   even parity over {cmd_op, cmd_addr, cmd_wdata}
//   rsp_valid   out  response at FIFO head
//   rsp_ready   in   initiator consumes the head response
//   rsp_data    out  read data / new register value (0 when empty)
//   rsp_err     out  illegal opcode or parity failure
//   rsp_count   out  response FIFO occupancy
module cmd_responder #(
   parameter int DATA_SIZE  = 8,
   parameter int ADDR_SIZE  = 8,
   parameter int CMD_SIZE   = 3,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [CMD_SIZE-1:0]           cmd_op,
   input  logic [ADDR_SIZE-1:0]          cmd_addr,
   input  logic [DATA_SIZE-1:0]          cmd_wdata,
   input  logic                          cmd_parity,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [DATA_SIZE-1:0]          rsp_data,
   output logic                          rsp_err,
   output logic [$clog2(FIFO_DEPTH):0]   rsp_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int REGS  = 1 << ADDR_SIZE;

   localparam logic [CMD_SIZE-1:0]  OP_NOP = CMD_SIZE'(0);
   localparam logic [CMD_SIZE-1:0]  OP_WR  = CMD_SIZE'(1);
   localparam logic [CMD_SIZE-1:0]  OP_RD  = CMD_SIZE'(2);
   localparam logic [CMD_SIZE-1:0]  OP_CLR = CMD_SIZE'(3);
   localparam logic [CMD_SIZE-1:0]  OP_INC = CMD_SIZE'(4);

   localparam logic [DATA_SIZE-1:0] DATA_ONE = DATA_SIZE'(1);
   localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);

   typedef enum logic {ST_READY, ST_STALL} state_t;

   state_t                 r_state;
   state_t                 w_state_next;

   logic [DATA_SIZE-1:0]   r_regs      [REGS];
   logic [DATA_SIZE-1:0]   r_fifo_data [FIFO_DEPTH];
   logic                   r_fifo_err  [FIFO_DEPTH];
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;
   logic [CNT_W-1:0]       w_count_next;

   logic                   w_accept;
   logic                   w_pop;
   logic                   w_push;
   logic                   w_par_err;
   logic                   w_reg_we;
   logic                   w_rsp_err_in;
   logic [DATA_SIZE-1:0]   w_cur;
   logic [DATA_SIZE-1:0]   w_new;
   logic [DATA_SIZE-1:0]   w_rsp_data_in;

`ifdef CMD_RESP_PARITY_EN
   // Even parity: the XOR of every command bit plus the parity bit is 0 when intact.
   assign w_par_err = ^{cmd_op, cmd_addr, cmd_wdata, cmd_parity};
`else
   logic w_unused_parity;
   assign w_unused_parity = cmd_parity;
   assign w_par_err       = 1'b0;
`endif

   assign w_cur    = r_regs[cmd_addr];
   assign w_accept = cmd_valid & cmd_ready;
   assign w_pop    = rsp_valid & rsp_ready;

   // Command decode: register update and the response entry for this accept.
   always_comb begin
      w_push        = 1'b0;
      w_reg_we      = 1'b0;
      w_new         = w_cur;
      w_rsp_data_in = '0;
      w_rsp_err_in  = 1'b0;
      if (w_accept) begin
         if (w_par_err) begin
            // Corrupted command: no side effect at all, even for NOP.
            w_push       = 1'b1;
            w_rsp_err_in = 1'b1;
         end else begin
            case (cmd_op)
               OP_NOP: begin
               end
               OP_WR: begin
                  w_new    = cmd_wdata;
                  w_reg_we = 1'b1;
               end
               OP_RD: begin
                  w_push        = 1'b1;
                  w_rsp_data_in = w_cur;
               end
               OP_CLR: begin
                  w_new    = '0;
                  w_reg_we = 1'b1;
               end
               OP_INC: begin
                  w_new    = w_cur + DATA_ONE;
                  w_reg_we = 1'b1;
               end
               default: begin
                  w_push       = 1'b1;
                  w_rsp_err_in = 1'b1;
               end
            endcase
            // Writing commands echo the post-update register value.
            if (w_reg_we) begin
               w_push        = 1'b1;
               w_rsp_data_in = w_new;
            end
         end
      end
   end

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CNT_ONE;
         2'b01:   w_count_next = r_count - CNT_ONE;
         default: w_count_next = r_count;
      endcase
   end

   // Flow-control FSM: decided from the post-edge occupancy so cmd_ready is a
   // pure register and never combinationally follows rsp_ready.
   always_comb begin
      w_state_next = r_state;
      cmd_ready    = 1'b0;
      case (r_state)
         ST_READY: begin
            cmd_ready = 1'b1;
            if (w_count_next == CNT_FULL) w_state_next = ST_STALL;
         end
         ST_STALL: begin
            cmd_ready = 1'b0;
            if (w_count_next < CNT_FULL) w_state_next = ST_READY;
         end
         default: w_state_next = ST_READY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_READY;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_next;
         r_count <= w_count_next;
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
   end

   // Storage is not reset; a command presented during reset must not touch it.
   always_ff @(posedge clk) begin
      if (!rst && w_push) begin
         r_fifo_data[r_wr_ptr] <= w_rsp_data_in;
         r_fifo_err[r_wr_ptr]  <= w_rsp_err_in;
      end
      if (!rst && w_reg_we) begin
         r_regs[cmd_addr] <= w_new;
      end
   end

   assign rsp_valid = (r_count != '0);
   assign rsp_data  = rsp_valid ? r_fifo_data[r_rd_ptr] : '0;
   assign rsp_err   = rsp_valid & r_fifo_err[r_rd_ptr];
   assign rsp_count = r_count;

endmodule

// File: tb/tb_cmd_responder.sv
// tb/tb_cmd_responder.sv - self-checking bench for cmd_responder
module tb_cmd_responder;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int CW = 3;
   localparam int FD = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [CW-1:0] cmd_op = '0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          cmd_parity = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [DW-1:0] rsp_data;
   logic          rsp_err;
   logic [3:0]    rsp_count;

   int checks = 0;
   int errors = 0;

   // Reference model: register array, queue of pending {err, data} responses,
   // and the expected cmd_ready (room was left after the previous edge).
   logic [7:0] m_mem [256];
   logic [8:0] m_q [$];
   logic       m_ready = 1'b1;

   cmd_responder #(
      .DATA_SIZE(DW), .ADDR_SIZE(AW), .CMD_SIZE(CW), .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_parity(cmd_parity),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_count(rsp_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      check({tag, ":valid"}, rsp_valid, (m_q.size() != 0));
      check({tag, ":count"}, rsp_count, m_q.size());
      check({tag, ":ready"}, cmd_ready, m_ready);
      if (m_q.size() != 0) begin
         check({tag, ":data"}, rsp_data, m_q[0][7:0]);
         check({tag, ":err"},  rsp_err,  m_q[0][8]);
      end
   endtask

   // One clock cycle: drive inputs, advance, update the model, compare.
   task automatic step(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] d, input logic bad_par, input logic rr,
                       input string tag);
      logic acc;
      logic pop;
      logic perr;
      cmd_valid  = v;
      cmd_op     = op;
      cmd_addr   = a;
      cmd_wdata  = d;
      cmd_parity = (^{op, a, d}) ^ bad_par;
      rsp_ready  = rr;
      acc = v && m_ready;
      pop = (m_q.size() != 0) && rr;
      @(posedge clk);
      #1;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
         perr = 1'b0;
`ifdef CMD_RESP_PARITY_EN
         perr = bad_par;
`endif
         if (perr) begin
            m_q.push_back({1'b1, 8'h00});
         end else if (op == 3'd0) begin
            // NOP: nothing
         end else if (op == 3'd1) begin
            m_mem[a] = d;
            m_q.push_back({1'b0, d});
         end else if (op == 3'd2) begin
            m_q.push_back({1'b0, m_mem[a]});
         end else if (op == 3'd3) begin
            m_mem[a] = 8'h00;
            m_q.push_back({1'b0, 8'h00});
         end else if (op == 3'd4) begin
            m_mem[a] = 8'((int'(m_mem[a]) + 1) % 256);
            m_q.push_back({1'b0, m_mem[a]});
         end else begin
            m_q.push_back({1'b1, 8'h00});
         end
      end
      m_ready = (m_q.size() < FD);
      check_outputs(tag);
   endtask

   task automatic do_reset(input logic v, input string tag);
      rst        = 1'b1;
      cmd_valid  = v;
      cmd_op     = 3'd2;
      cmd_addr   = 8'h50;
      cmd_wdata  = 8'h00;
      cmd_parity = 1'b1;
      rsp_ready  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_q.delete();
      m_ready = 1'b1;
      check({tag, ":valid"}, rsp_valid, 0);
      check({tag, ":count"}, rsp_count, 0);
      check({tag, ":ready"}, cmd_ready, 1);
      check({tag, ":data"},  rsp_data,  0);
      check({tag, ":err"},   rsp_err,   0);
   endtask

   task automatic drain(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b1, "drain");
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset(1'b0, "reset");

      // WR then RD of the same register; response visible right after accept.
      step(1'b1, 3'd1, 8'h10, 8'hA5, 1'b0, 1'b0, "wr10");
      check("wr_latency_valid", rsp_valid, 1);
      check("wr_latency_data", rsp_data, 8'hA5);
      step(1'b1, 3'd2, 8'h10, 8'h00, 1'b0, 1'b1, "rd10");
      drain(3);

      // Increment wraps, then clear.
      step(1'b1, 3'd1, 8'h20, 8'hFF, 1'b0, 1'b1, "wr20");
      step(1'b1, 3'd4, 8'h20, 8'h00, 1'b0, 1'b1, "inc20");
      check("inc_wrap", rsp_data, 8'h00);
      step(1'b1, 3'd2, 8'h20, 8'h00, 1'b0, 1'b1, "rd20");
      step(1'b1, 3'd3, 8'h20, 8'h77, 1'b0, 1'b1, "clr20");
      drain(3);

      // Illegal opcode, register untouched, NOP silent.
      step(1'b1, 3'd6, 8'h10, 8'h33, 1'b0, 1'b0, "illegal");
      check("illegal_err", rsp_err, 1);
      step(1'b1, 3'd2, 8'h10, 8'h00, 1'b0, 1'b1, "rd10b");
      drain(2);
      step(1'b1, 3'd0, 8'h10, 8'h00, 1'b0, 1'b1, "nop");
      check("nop_count", rsp_count, 0);

      // Seed 0x50..0x58 for the stall test and the random phase.
      for (int i = 0; i < 9; i++)
         step(1'b1, 3'd1, 8'(8'h50 + i), 8'($urandom), 1'b0, 1'b1, "seed");
      drain(2);

      // Fill the FIFO with 9 held reads; the 9th must wait for a pop.
      for (int i = 0; i < 9; i++)
         step(1'b1, 3'd2, 8'(8'h50 + i), 8'h00, 1'b0, 1'b0, "fill");
      check("full_count", rsp_count, 8);
      check("full_ready", cmd_ready, 0);
      step(1'b1, 3'd2, 8'h58, 8'h00, 1'b0, 1'b1, "one_pop");
      check("pop_count", rsp_count, 7);
      check("pop_ready", cmd_ready, 1);
      step(1'b1, 3'd2, 8'h58, 8'h00, 1'b0, 1'b0, "ninth");
      check("ninth_count", rsp_count, 8);
      drain(10);

      // Steady push+pop at occupancy 3; pointers wrap several times.
      for (int i = 0; i < 3; i++)
         step(1'b1, 3'd2, 8'(8'h50 + i), 8'h00, 1'b0, 1'b0, "pre3");
      for (int i = 0; i < 20; i++)
         step(1'b1, ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd2,
              8'(8'h50 + $urandom_range(0, 8)), 8'($urandom), 1'b0, 1'b1, "steady");
      check("steady_count", rsp_count, 3);

      // Reset mid-stream: queue dropped, register file kept.
      do_reset(1'b1, "mid_reset");
      step(1'b1, 3'd2, 8'h50, 8'h00, 1'b0, 1'b1, "rd_after_rst");
      check("rd_after_rst_data", rsp_data, m_mem[8'h50]);
      drain(2);

      // Parity corruption on a write.
      step(1'b1, 3'd1, 8'h30, 8'h11, 1'b0, 1'b1, "wr30");
      step(1'b1, 3'd1, 8'h30, 8'h55, 1'b1, 1'b1, "wr30_badpar");
`ifdef CMD_RESP_PARITY_EN
      check("badpar_err", rsp_err, 1);
`else
      check("badpar_ignored", rsp_data, 8'h55);
`endif
      step(1'b1, 3'd2, 8'h30, 8'h00, 1'b0, 1'b1, "rd30");
      drain(2);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              8'(8'h50 + $urandom_range(0, 8)), 8'($urandom),
              $urandom_range(0, 9) == 0, $urandom_range(0, 1) != 0, "rand");
      drain(12);
      check("final_empty", rsp_count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
